// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment patterns are active-high with bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high segments.
// Non-BCD codes (10..15) show a single dash so bad data is visible on the display.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Map each digit to its segment pattern
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver.
// Each digit slot is REFRESH_DIV cycles: GAP_CYC cycles with every anode off
// (anti-ghosting), then the digit is shown. Inputs are snapshotted once per
// frame at the start of slot 0 so a frame never mixes old and new values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int GAP_CYC        = 500,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Qdata3,
  input  logic [3:0] Qdata2,
  input  logic [3:0] Qdata1,
  input  logic [3:0] Qdata0,
  input  logic [3:0] dp_mask,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_sel,
  output logic       frame_done,
  output logic       err_bcd
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // XOR masks that turn active-high values into the pin polarity
  localparam logic [3:0] AN_POL  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_POL  = SEG_ACTIVE_LOW;

  localparam logic [3:0] AN_IDLE  = 4'h0 ^ AN_POL;
  localparam logic [6:0] SEG_IDLE = SEG_OFF ^ SEG_POL;
  localparam logic       DP_IDLE  = 1'b0 ^ DP_POL;

  // True when any snapshot digit is outside 0..9
  function automatic logic any_nonbcd(input logic [N_DIGITS-1:0][3:0] d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (d[i] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]   snap_dig_q, snap_dig_d;
  logic [3:0]                 snap_dp_q, snap_dp_d;
  logic                       snap_blank_q, snap_blank_d;
  logic [3:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic                       fd_q, fd_d;
  logic                       err_q, err_d;

  logic                       capture;
  logic                       slot_end;
  logic                       show_start;
  logic [N_DIGITS-1:0][3:0]   view_dig;
  logic [3:0]                 view_dp;
  logic                       view_blank;
  logic [3:0]                 blank_vec;
  logic [3:0]                 cur_dig;
  logic [6:0]                 cur_seg;

  // Slot timing events and the values seen by the digit about to be shown.
  // On the capture cycle the fresh inputs are forwarded so a first SHOW that
  // coincides with capture (GAP_CYC == 1) already uses the new frame.
  always_comb begin
    capture    = (state_q == GAP) && (idx_q == 2'd0) && (cnt_q == '0);
    slot_end   = (cnt_q == CNT_LAST);
    show_start = (state_q == GAP) && (cnt_q == GAP_LAST);
    view_dig   = capture ? {Qdata3, Qdata2, Qdata1, Qdata0} : snap_dig_q;
    view_dp    = capture ? dp_mask  : snap_dp_q;
    view_blank = capture ? blank_en : snap_blank_q;
    blank_vec[3] = view_blank   && (view_dig[3] == 4'd0);
    blank_vec[2] = blank_vec[3] && (view_dig[2] == 4'd0);
    blank_vec[1] = blank_vec[2] && (view_dig[1] == 4'd0);
    blank_vec[0] = 1'b0;
    cur_dig    = view_dig[idx_q];
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_dig),
    .seg_o (cur_seg)
  );

  // Next-state for slot counter, FSM, snapshot and registered outputs
  always_comb begin
    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
    state_d      = state_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    fd_d         = slot_end && (idx_q == 2'd3);
    err_d        = any_nonbcd(snap_dig_q);

    if (capture) begin
      snap_dig_d   = {Qdata3, Qdata2, Qdata1, Qdata0};
      snap_dp_d    = dp_mask;
      snap_blank_d = blank_en;
    end

    if (slot_end) begin
      state_d = GAP;
      an_d    = AN_IDLE;
      seg_d   = SEG_IDLE;
      dp_d    = DP_IDLE;
    end else if (show_start) begin
      state_d = SHOW;
      if (blank_vec[idx_q]) begin
        an_d  = AN_IDLE;
        seg_d = SEG_IDLE;
        dp_d  = DP_IDLE;
      end else begin
        an_d  = (4'b0001 << idx_q) ^ AN_POL;
        seg_d = cur_seg ^ SEG_POL;
        dp_d  = view_dp[idx_q] ^ DP_POL;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GAP;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      snap_dig_q   <= '0;
      snap_dp_q    <= 4'h0;
      snap_blank_q <= 1'b0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      fd_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
      err_q        <= err_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = idx_q;
  assign frame_done = fd_q;
  assign err_bcd    = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=8, GAP_CYC=2,
// active-low anodes and segments. A timeline model predicts every output
// each cycle; expectations are queued at the clock edge and compared 1 ns later.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q3, q2, q1, q0;
  logic [3:0] dp_mask;
  logic       blank_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_sel;
  logic       frame_done;
  logic       err_bcd;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV    (RD),
    .GAP_CYC        (GC),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Qdata3     (q3),
    .Qdata2     (q2),
    .Qdata1     (q1),
    .Qdata0     (q0),
    .dp_mask    (dp_mask),
    .blank_en   (blank_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .err_bcd    (err_bcd)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
    logic       fd;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: t = edges since reset release; snapshot of the current frame
  int         t = 0;
  logic [3:0] m_d [4];
  logic [3:0] m_dp;
  logic       m_blank;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0d time=%0t", tag, obs, exp, t, $time);
    end
  endtask

  // Advance the model by one clock edge and push the expected outputs
  task automatic model_edge();
    exp_t e;
    int   cnt, slot;
    logic bl3, bl2, bl1;
    logic blanked;
    if (rst) begin
      t = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      m_dp    = 4'd0;
      m_blank = 1'b0;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, sel: 2'd0, fd: 1'b0, err: 1'b0};
    end else begin
      e.err = (m_d[0] > 9) || (m_d[1] > 9) || (m_d[2] > 9) || (m_d[3] > 9);
      if (t % FRAME == 0) begin
        m_d[0] = q0; m_d[1] = q1; m_d[2] = q2; m_d[3] = q3;
        m_dp    = dp_mask;
        m_blank = blank_en;
      end
      t++;
      cnt   = t % RD;
      slot  = (t / RD) % 4;
      e.sel = 2'(slot);
      e.fd  = (t % FRAME == 0);
      bl3 = m_blank && (m_d[3] == 0);
      bl2 = bl3 && (m_d[2] == 0);
      bl1 = bl2 && (m_d[1] == 0);
      case (slot)
        3:       blanked = bl3;
        2:       blanked = bl2;
        1:       blanked = bl1;
        default: blanked = 1'b0;
      endcase
      if (cnt >= GC && !blanked) begin
        e.an  = ~(4'b0001 << slot);
        e.seg = ~seg_pat(m_d[slot]);
        e.dp  = ~m_dp[slot];
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      e = sb_q.pop_front();
      chk("an",         an,         e.an);
      chk("seg",        seg,        e.seg);
      chk("dp",         dp,         e.dp);
      chk("digit_sel",  digit_sel,  e.sel);
      chk("frame_done", frame_done, e.fd);
      chk("err_bcd",    err_bcd,    e.err);
    end
  endtask

  // Run until the frame position (t mod 32) equals pos, bounded to 40 edges
  task automatic run_until(input int pos);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (t % FRAME == pos) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("run_until_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    q3 = 4'd1; q2 = 4'd2; q1 = 4'd3; q0 = 4'd4;
    dp_mask  = 4'b0000;
    blank_en = 1'b0;

    // Reset state and basic scan of 1,2,3,4
    run(2);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    rst = 1'b0;
    run(1);
    chk("s1_gap_an", an, 4'hF);
    run(1);
    chk("s1_an_slot0", an, 4'b1110);
    chk("s1_seg_slot0", seg, 7'h7F ^ 7'h66);
    run_until(0);
    chk("s1_frame_done", frame_done, 1'b1);
    run(2 * FRAME);

    // Leading-zero blanking
    q3 = 4'd0; q2 = 4'd0; q1 = 4'd0; q0 = 4'd7;
    blank_en = 1'b1;
    run_until(1);
    run_until(2);
    chk("s2_an_slot0", an, 4'b1110);
    chk("s2_seg_slot0", seg, 7'h7F ^ 7'h07);
    run_until(26);
    chk("s2_an_slot3", an, 4'hF);
    q0 = 4'd0;
    run_until(1);
    run_until(2);
    chk("s2_zero_an", an, 4'b1110);
    chk("s2_zero_seg", seg, 7'h7F ^ 7'h3F);
    run_until(10);
    chk("s2_zero_slot1", an, 4'hF);
    blank_en = 1'b0;

    // Mid-frame input change must not tear the frame
    q3 = 4'd5; q2 = 4'd6; q1 = 4'd7; q0 = 4'd8;
    run_until(1);
    run_until(18);
    q3 = 4'd9; q2 = 4'd9; q1 = 4'd9; q0 = 4'd9;
    chk("s3_slot2", seg, 7'h7F ^ 7'h7D);
    run_until(26);
    chk("s3_slot3", seg, 7'h7F ^ 7'h6D);
    run_until(0);
    chk("s3_fd", frame_done, 1'b1);
    run_until(2);
    chk("s3_new", seg, 7'h7F ^ 7'h6F);

    // Non-BCD digit: dash and err_bcd
    q1 = 4'hC;
    run_until(1);
    chk("s4_err_pre", err_bcd, 1'b0);
    run_until(2);
    chk("s4_err_set", err_bcd, 1'b1);
    run_until(12);
    chk("s4_dash_an", an, 4'b1101);
    chk("s4_dash_seg", seg, 7'h7F ^ 7'h40);
    q1 = 4'd3;
    run_until(1);
    chk("s4_err_hold", err_bcd, 1'b1);
    run_until(2);
    chk("s4_err_clr", err_bcd, 1'b0);

    // Reset pulse during SHOW
    run_until(12);
    rst = 1'b1;
    run(1);
    chk("s5_an", an, 4'hF);
    chk("s5_seg", seg, 7'h7F);
    chk("s5_sel", digit_sel, 2'd0);
    chk("s5_fd", frame_done, 1'b0);
    rst = 1'b0;
    run(1);
    chk("s5_gap", an, 4'hF);
    run(1);
    chk("s5_show", an, 4'b1110);
    run(FRAME);

    // Decimal point on digit 2 only
    dp_mask = 4'b0100;
    run_until(1);
    run_until(18);
    chk("s6_dp_slot2", dp, 1'b0);
    run_until(26);
    chk("s6_dp_slot3", dp, 1'b1);
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 4-digit BCD counter outputs (Qdata3..Qdata0). It time-multiplexes the four digits onto a common-segment 7-segment display: one anode is active at a time, segments are decoded from BCD, and a short blanking gap between digits suppresses ghosting. It also provides optional leading-zero blanking, per-digit decimal points, a frame-done pulse and a non-BCD error flag.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (GAP + SHOW); legal range 4..2^20.
GAP_CYC, 500, cycles at the start of each slot with all anodes off; 1 <= GAP_CYC < REFRESH_DIV.
AN_ACTIVE_LOW, 1, 1 means anode outputs are active-low.
SEG_ACTIVE_LOW, 1, 1 means seg and dp outputs are active-low.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous reset, active-high.
Qdata3  in  4  most significant BCD digit.
Qdata2  in  4  BCD digit 2.
Qdata1  in  4  BCD digit 1.
Qdata0  in  4  least significant BCD digit.
dp_mask  in  4  decimal point enables; bit i maps to digit i.
blank_en  in  1  enables leading-zero blanking.
an  out  4  anode drives; bit i maps to digit i.
seg  out  7  segment drives; seg[0]=a ... seg[6]=g.
dp  out  1  decimal point drive.
digit_sel  out  2  index of the current slot.
frame_done  out  1  one-cycle pulse at the start of each new frame.
err_bcd  out  1  high while the captured snapshot holds any digit greater than 9.

Behaviour:
- Reset is synchronous: on any clk edge with rst=1 the block loads its reset state; rst has no asynchronous path.
- Reset values:
  - cnt=0, idx=0, state=GAP.
  - snapshot (digits, dp_mask, blank_en)=0.
  - an=all inactive; seg=all off; dp=off.
  - digit_sel=0, frame_done=0, err_bcd=0.
- Slot counter: cnt runs 0..REFRESH_DIV-1.
  - On cnt==REFRESH_DIV-1: cnt<=0, idx<=idx+1 (wraps 3->0), state<=GAP.
- FSM: two states.
  - GAP covers cnt 0..GAP_CYC-1.
  - SHOW covers cnt GAP_CYC..REFRESH_DIV-1.
  - At the edge where cnt==GAP_CYC-1, state<=SHOW.
- Snapshot: captures Qdata3..0, dp_mask and blank_en on every edge where state==GAP, idx==0 and cnt==0.
  - This includes the first cycle after reset deasserts.
  - Inputs that change mid-frame do not affect the frame in progress, so there is no tearing.
- Outputs are registered.
  - On the GAP->SHOW edge: an<=one-hot(idx) unless the digit is blanked; seg<=decode(snapshot digit idx); dp<=dp_mask_snap[idx].
  - On the SHOW->GAP edge: an, seg and dp<=off.
  - Result: an is active exactly REFRESH_DIV-GAP_CYC cycles per slot.
- Polarity is applied at the output register per AN_ACTIVE_LOW and SEG_ACTIVE_LOW.
- digit_sel mirrors idx.
- frame_done is registered. It is high for exactly one cycle, the cycle where idx==0 and cnt==0 after a wrap from idx 3. It is not asserted after reset.
- Decode:
  - Digits 0-9 use the standard patterns.
  - Digits 10-15 display a dash (g only).
  - err_bcd updates one cycle after each snapshot capture.
- Leading-zero blanking (only when blank_en_snap=1):
  - d3 is blanked if d3==0.
  - d2 is blanked if d3==0 and d2==0.
  - d1 is blanked if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - A blanked digit keeps an inactive for the whole slot; seg and dp are also off.
- Reset mid-slot: all outputs return to their reset state on the next edge, with no partial-slot continuation.
- Simultaneous events: at a frame wrap, snapshot capture and frame_done fall on the same cycle. The first SHOW of digit 0 uses the newly captured values.

Decomposition:
- Package seg7_pkg holds:
  - the SEG_0..SEG_9, SEG_DASH and SEG_OFF constants (active-high form);
  - the state enum {GAP, SHOW};
  - N_DIGITS=4.
- One sub-module, bcd_to_seg7: combinational, 4-bit in, 7-bit active-high out. The top module instantiates it once, on the muxed snapshot digit.

Test Plan:
Use REFRESH_DIV=8, GAP_CYC=2 and active-low polarity for all scenarios.
1. Reset, then Qdata=1,2,3,4 and blank_en=0 -> slot 0 has an=1110 and seg=~SEG_4 during cnt 2..7. Slots follow 0,1,2,3. frame_done pulses every 32 cycles.
2. Qdata=0,0,0,7 and blank_en=1 -> an stays 1111 in slots 3, 2 and 1; slot 0 shows 7. With Qdata=0 on all digits, only digit 0 shows 0.
3. Change Qdata during slot 2 -> displayed values are unchanged until the next frame. The new value appears in the slot-0 SHOW after frame_done.
4. Qdata1=4'hC -> slot 1 shows a dash (seg=~7'b1000000). err_bcd is high starting the cycle after capture and clears the frame after a valid value is captured.
5. Assert rst for 1 cycle during a SHOW -> next edge gives an=1111, seg=7F, digit_sel=0, frame_done=0. The first SHOW starts 2 cycles after release.
6. dp_mask=0100 -> dp is low only during the slot-2 SHOW cycles and high otherwise.
